// File: rtl/demux8_1x2_stream_pkg.sv
// Shared slot state encoding and counter width for the 1:2 stream demux.
package demux8_1x2_stream_pkg;

  localparam int CNT_W = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: loads a byte, presents it until drained, counts deliveries.
// Load and drain in the same cycle replaces the byte without a bubble; drain is valid&ready.
module demux_slot
  import demux8_1x2_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  slot_state_t state;
  logic        drain;

  assign valid = (state == SLOT_FULL);
  assign drain = valid && drain_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      data  <= '0;
      count <= '0;
    end else begin
      if (drain) begin
        count <= count + 1'b1;
      end
      // A fresh load wins over the drain so the slot stays full at full throughput.
      if (load) begin
        state <= SLOT_FULL;
        data  <= load_data;
      end else if (drain) begin
        state <= SLOT_EMPTY;
      end
    end
  end

endmodule

// File: rtl/demux8_1x2_stream.sv
// Routes each input byte to out1 (sel=1) or out2 (sel=0); one-cycle latency into a slot.
// in_ready follows the selected slot: free or draining this cycle; held low during reset.
module demux8_1x2_stream
  import demux8_1x2_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  logic accept;
  logic load1;
  logic load2;

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = in_sel ? (!out1_valid || out1_ready) : (!out2_valid || out2_ready);
    end
  end

  assign accept = in_valid && in_ready;
  assign load1  = accept && in_sel;
  assign load2  = accept && !in_sel;

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk        (clk),
    .rst        (rst),
    .load       (load1),
    .load_data  (in_data),
    .drain_ready(out1_ready),
    .data       (out1_data),
    .valid      (out1_valid),
    .count      (cnt1)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot2 (
    .clk        (clk),
    .rst        (rst),
    .load       (load2),
    .load_data  (in_data),
    .drain_ready(out2_ready),
    .data       (out2_data),
    .valid      (out2_valid),
    .count      (cnt2)
  );

endmodule

// File: tb/tb_demux8_1x2_stream.sv
// Directed plus random bench for the 1:2 stream demux against a queue-based reference.
module tb_demux8_1x2_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sel;
  logic       in_ready;
  logic [7:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [7:0] out2_data;
  logic       out2_valid;
  logic       out2_ready;
  logic [7:0] cnt1;
  logic [7:0] cnt2;

  int total = 0;
  int bad   = 0;

  // Reference: index 0 is out1, index 1 is out2. Each destination buffers at most one byte.
  logic [7:0] mq   [2][$];
  logic [7:0] mdat [2];
  logic [7:0] mcnt [2];

  always #5 clk = ~clk;

  demux8_1x2_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .out1_data (out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out2_data (out2_data),
    .out2_valid(out2_valid),
    .out2_ready(out2_ready),
    .cnt1      (cnt1),
    .cnt2      (cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check DUT against the model before the edge, then advance the model.
  task automatic cyc(input logic r, input logic v, input logic s, input logic [7:0] d,
                     input logic r1, input logic r2, input bit en);
    logic exp_ready;
    logic rdy [2];
    int   dest;
    rst = r; in_valid = v; in_sel = s; in_data = d; out1_ready = r1; out2_ready = r2;
    rdy[0] = r1;
    rdy[1] = r2;
    dest = s ? 0 : 1;
    #1;
    exp_ready = r ? 1'b0 : ((mq[dest].size() == 0) || rdy[dest]);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    if (en) begin
      chk("out1_valid", {31'd0, out1_valid}, {31'd0, mq[0].size() != 0});
      chk("out2_valid", {31'd0, out2_valid}, {31'd0, mq[1].size() != 0});
      chk("out1_data", {24'd0, out1_data}, {24'd0, mdat[0]});
      chk("out2_data", {24'd0, out2_data}, {24'd0, mdat[1]});
      chk("cnt1", {24'd0, cnt1}, {24'd0, mcnt[0]});
      chk("cnt2", {24'd0, cnt2}, {24'd0, mcnt[1]});
    end
    if (r) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        mdat[k] = 8'h00;
        mcnt[k] = 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mq[k].size() > 0 && rdy[k]) begin
          void'(mq[k].pop_front());
          mcnt[k] = mcnt[k] + 8'd1;
        end
      end
      if (v && exp_ready) begin
        mq[dest].push_back(d);
        mdat[dest] = d;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] c;
    for (int k = 0; k < 2; k++) begin
      mdat[k] = 8'h00;
      mcnt[k] = 8'h00;
    end
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = 8'h00;
    out1_ready = 1'b0; out2_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset with in_valid asserted: slots empty, counters zero, in_ready low.
    cyc(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'hEE, 1'b1, 1'b1, 1'b1);
    chk("rst_v1", {31'd0, out1_valid}, 32'd0);
    chk("rst_cnt2", {24'd0, cnt2}, 32'd0);

    // Routing, with acceptance on the first edge after reset falls.
    cyc(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
    chk("route_a5", {24'd0, out1_data}, 32'hA5);
    chk("route_a5_v", {31'd0, out1_valid}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("route_3c", {24'd0, out2_data}, 32'h3C);
    chk("route_cnt1", {24'd0, cnt1}, 32'd1);
    chk("route_cnt2", {24'd0, cnt2}, 32'd1);

    // Backpressure on out1; out2 still accepts.
    cyc(1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1);
    chk("bp_hold", {24'd0, out1_data}, 32'h11);
    rst = 1'b0; in_valid = 1'b1; in_sel = 1'b1; out1_ready = 1'b0;
    #1;
    chk("bp_ready", {31'd0, in_ready}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 1'b1);
    chk("bp_out2", {24'd0, out2_data}, 32'h33);
    chk("bp_out1", {24'd0, out1_data}, 32'h11);

    // Simultaneous drain and load on out1.
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1);
    c = cnt1;
    cyc(1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
    chk("sim_v", {31'd0, out1_valid}, 32'd1);
    chk("sim_d", {24'd0, out1_data}, 32'h55);
    chk("sim_cnt", {24'd0, cnt1}, {24'd0, c + 8'd1});

    // 256 deliveries on out2 bring cnt2 back to where it started.
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    c = cnt2;
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'(i), 1'b0, 1'b1, 1'b1);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("wrap_cnt2", {24'd0, cnt2}, {24'd0, c});

    // Mid-stream reset with both slots full.
    cyc(1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 8'h88, 1'b0, 1'b0, 1'b1);
    chk("mid_full1", {31'd0, out1_valid}, 32'd1);
    chk("mid_full2", {31'd0, out2_valid}, 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 1'b1, 1'b1);
    chk("mid_v1", {31'd0, out1_valid}, 32'd0);
    chk("mid_v2", {31'd0, out2_valid}, 32'd0);
    chk("mid_c1", {24'd0, cnt1}, 32'd0);
    chk("mid_c2", {24'd0, cnt2}, 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(63) == 0, 1'($urandom), 1'($urandom), 8'($urandom),
          $urandom_range(3) != 0, $urandom_range(1) != 0, 1'b1);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux8_1x2_stream.md
DEMUX8_1X2_STREAM -- requirements
Module: demux8_1x2_stream

Interface
REQ-001 Parameter: WIDTH, default 8, data width of input and both outputs.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_data  input  WIDTH  byte to route.
REQ-006 Port: in_valid  input  1  in_data and in_sel are valid.
REQ-007 Port: in_sel  input  1  destination: 1 routes to out1, 0 routes to out2.
REQ-008 Port: in_ready  output  1  the block accepts in_data this cycle.
REQ-009 Port: out1_data / out2_data  output  WIDTH  held byte per destination.
REQ-010 Port: out1_valid / out2_valid  output  1  slot holds an undelivered byte.
REQ-011 Port: out1_ready / out2_ready  input  1  downstream accepts the byte.
REQ-012 Port: cnt1 / cnt2  output  8  delivered-byte count per destination.

Function
REQ-013 Input handshake SHALL occur on a cycle with in_valid=1 and in_ready=1; output handshake N SHALL occur on a cycle with outN_valid=1 and outN_ready=1.
REQ-014 in_ready SHALL be combinational: for in_sel=1 it equals (!out1_valid | out1_ready); for in_sel=0 it equals (!out2_valid | out2_ready); it is 0 while rst=1.
REQ-015 Each destination SHALL have one slot with states EMPTY (outN_valid=0) and FULL (outN_valid=1).
REQ-016 Transitions: EMPTY->FULL on input handshake to N; FULL->EMPTY on output handshake N without input handshake to N; FULL->FULL with new data on simultaneous output and input handshake to N; otherwise hold.
REQ-017 Latency SHALL be one cycle: a byte accepted at edge k appears on outN_data with outN_valid=1 from edge k onward.
REQ-018 outN_data SHALL stay stable while outN_valid=1 and outN_ready=0.
REQ-019 The non-selected slot SHALL be unaffected by an input handshake.
REQ-020 in_sel and in_data SHALL be ignored when in_valid=0.
REQ-021 Full throughput: one byte per cycle to a destination whose outN_ready is held 1.
REQ-022 cntN SHALL increment by 1 on each output handshake N and wrap 255->0.
REQ-023 Byte order per destination SHALL be preserved; no byte dropped or duplicated.

Reset
REQ-024 While rst=1 at a rising edge: out1_valid=out2_valid=0, out1_data=out2_data=0, cnt1=cnt2=0.
REQ-025 Reset mid-operation SHALL discard held bytes; no handshake completes on a reset cycle.
REQ-026 First input acceptance SHALL be possible on the first edge after rst falls.

Structure
REQ-027 Slot state encodings (SLOT_EMPTY=0, SLOT_FULL=1) SHALL live in a shared definitions include used by both slot and top.
REQ-028 One sub-module demux_slot (WIDTH parameter, load/drain ports, data/valid/count outputs) SHALL be instantiated twice.
REQ-029 Top level SHALL contain only ready steering, load decode from in_sel, and slot instances.

Verification
REQ-030 Reset: drive rst=1 with in_valid=1 -> out1_valid=out2_valid=0, cnt1=cnt2=0, in_ready=0.
REQ-031 Routing: send 0xA5 sel=1, then 0x3C sel=0, both readies=1 -> out1_data=0xA5 one cycle after acceptance, out2_data=0x3C, cnt1=cnt2=1.
REQ-032 Backpressure: out1_ready=0, send 0x11 then 0x22 sel=1 -> 0x11 held, in_ready=0 for sel=1; sel=0 byte 0x33 still accepted to out2.
REQ-033 Simultaneous: out1 FULL with 0x44, out1_ready=1, in 0x55 sel=1 same cycle -> out1_valid stays 1, out1_data=0x55, cnt1 increments.
REQ-034 Wrap: 256 handshakes on out2 -> cnt2 returns to 0.
REQ-035 Mid-stream reset with both slots FULL -> next cycle both valids 0, counters 0.
